// File: rtl/one_bit_full_adder_pkg.sv
// Shared constants for the one-bit full adder slice.
// Widths used by the adder top and its reference checker.
package one_bit_full_adder_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int RES_W     = 2;

endpackage

// File: rtl/fa_core.sv
// Combinational full-adder core.
// Pure gates, no clock or reset involvement.
module fa_core (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/one_bit_full_adder.sv
// One-bit full adder with registered result,
// saturating carry counter and sticky self-check.
module one_bit_full_adder
    import one_bit_full_adder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             sum,
    output logic             cout,
    input  logic             in_valid,
    output logic             sum_q,
    output logic             cout_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             fa_sum;
    logic             fa_cout;
    logic [RES_W-1:0] ref_res;
    logic             mismatch;

    fa_core u_core (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign sum  = fa_sum;
    assign cout = fa_cout;

    // Independent arithmetic reference for the gate-level core
    assign ref_res  = RES_W'(a) + RES_W'(b) + RES_W'(cin);
    assign mismatch = ({fa_cout, fa_sum} != ref_res);

    // Capture the result on accepted edges; out_valid pulses per accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= 1'b0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum_q     <= fa_sum;
            cout_q    <= fa_cout;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Count accepted carries, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (in_valid && fa_cout && carry_cnt != CNT_MAX) begin
            carry_cnt <= carry_cnt + 1'b1;
        end
    end

    // Sticky error: once a mismatch is accepted only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (in_valid && mismatch) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_one_bit_full_adder.sv
// Self-checking bench for one_bit_full_adder.
// Random stimulus against an arithmetic model plus directed cases.
module tb_one_bit_full_adder;

    logic        clk;
    logic        clk_run;
    logic        rst_n;
    logic        a, b, cin, in_valid;
    logic        sum, cout, sum_q, cout_q, out_valid, err;
    logic [15:0] carry_cnt;

    logic        s_sum, s_cout, s_sum_q, s_cout_q, s_vld, s_err;
    logic [1:0]  s_cnt;

    logic [3:0]  ra, rb, rs;
    logic [4:0]  rc;
    logic [3:0]  r_sq, r_cq, r_vld, r_err;
    logic [3:0]  r_cnt [4];

    int total = 0;
    int bad   = 0;
    logic chk_en;

    int m_sum_q, m_cout_q, m_vld, m_cnt, m_cnt2;

    one_bit_full_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .in_valid  (in_valid),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .out_valid (out_valid),
        .carry_cnt (carry_cnt),
        .err       (err)
    );

    one_bit_full_adder #(.CNT_W(2)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (s_sum),
        .cout      (s_cout),
        .in_valid  (in_valid),
        .sum_q     (s_sum_q),
        .cout_q    (s_cout_q),
        .out_valid (s_vld),
        .carry_cnt (s_cnt),
        .err       (s_err)
    );

    assign rc[0] = 1'b0;
    for (genvar g = 0; g < 4; g++) begin : g_rip
        one_bit_full_adder #(.CNT_W(4)) u_fa (
            .clk       (clk),
            .rst_n     (rst_n),
            .a         (ra[g]),
            .b         (rb[g]),
            .cin       (rc[g]),
            .sum       (rs[g]),
            .cout      (rc[g+1]),
            .in_valid  (1'b0),
            .sum_q     (r_sq[g]),
            .cout_q    (r_cq[g]),
            .out_valid (r_vld[g]),
            .carry_cnt (r_cnt[g]),
            .err       (r_err[g])
        );
    end

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    function automatic int add3(input logic x, input logic y, input logic z);
        return int'(x) + int'(y) + int'(z);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the registered outputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum_q  <= 0;
            m_cout_q <= 0;
            m_vld    <= 0;
            m_cnt    <= 0;
            m_cnt2   <= 0;
        end else if (in_valid) begin
            m_sum_q  <= add3(a, b, cin) % 2;
            m_cout_q <= add3(a, b, cin) / 2;
            m_vld    <= 1;
            if (add3(a, b, cin) >= 2) begin
                m_cnt  <= (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
                m_cnt2 <= (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            end
        end else begin
            m_vld <= 0;
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("sum",       sum,       add3(a, b, cin) % 2);
            check("cout",      cout,      add3(a, b, cin) / 2);
            check("sum_q",     sum_q,     m_sum_q);
            check("cout_q",    cout_q,    m_cout_q);
            check("out_valid", out_valid, m_vld);
            check("carry_cnt", carry_cnt, m_cnt);
            check("small_cnt", s_cnt,     m_cnt2);
            check("err",       err,       0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ripple(input logic [3:0] x, input logic [3:0] y);
        int r;
        ra = x;
        rb = y;
        #1;
        r = int'(x) + int'(y);
        check("ripple_sum",   rs,    r % 16);
        check("ripple_carry", rc[4], r / 16);
    endtask

    initial begin
        clk_run  = 1'b0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0;
        ra = '0; rb = '0;
        #1;

        check("rst_sum_q",     sum_q,     0);
        check("rst_cout_q",    cout_q,    0);
        check("rst_out_valid", out_valid, 0);
        check("rst_carry_cnt", carry_cnt, 0);
        check("rst_err",       err,       0);

        // Combinational path with clock idle and reset held
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = 3'(i);
            #1;
            check("comb_sum",  sum,  add3(a, b, cin) % 2);
            check("comb_cout", cout, add3(a, b, cin) / 2);
        end
        {a, b, cin} = 3'b111; #1;
        check("lit111_sum", sum, 1);
        check("lit111_cout", cout, 1);
        {a, b, cin} = 3'b100; #1;
        check("lit100_sum", sum, 1);
        check("lit100_cout", cout, 0);
        {a, b, cin} = 3'b000; #1;
        check("lit000_sum", sum, 0);
        check("lit000_cout", cout, 0);

        rst_n   = 1'b1;
        #1;
        clk_run = 1'b1;
        chk_en  = 1'b1;
        step();

        // Directed registered-path case
        a = 1'b1; b = 1'b1; cin = 1'b0; in_valid = 1'b1;
        step();
        check("dir_sum_q",  sum_q,     0);
        check("dir_cout_q", cout_q,    1);
        check("dir_vld",    out_valid, 1);
        in_valid = 1'b0; a = 1'b0;
        step();
        check("hold_vld",    out_valid, 0);
        check("hold_sum_q",  sum_q,     0);
        check("hold_cout_q", cout_q,    1);

        // Accept all 8 combinations
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = 3'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        check("err_clean", err, 0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            a        = 1'($urandom);
            b        = 1'($urandom);
            cin      = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        // Async reset between edges
        rst_n = 1'b0;
        #1;
        check("mid_sum_q",  sum_q,     0);
        check("mid_cout_q", cout_q,    0);
        check("mid_vld",    out_valid, 0);
        check("mid_cnt",    carry_cnt, 0);
        check("mid_err",    err,       0);
        a = 1'b1; b = 1'b0; cin = 1'b1; #1;
        check("mid_sum",  sum,  0);
        check("mid_cout", cout, 1);
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        check("post_rst_vld", out_valid, 0);
        a = 1'b1; b = 1'b1; cin = 1'b1; in_valid = 1'b1;
        step();
        check("post_rst_vld1", out_valid, 1);
        check("post_rst_sq",   sum_q,     1);

        // Saturation of the 2-bit counter
        rst_n = 1'b0; #1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        step();
        check("sat_small_cnt", s_cnt,     3);
        check("sat_big_cnt",   carry_cnt, 5);

        // Ripple chain
        ripple(4'b1011, 4'b0110);
        check("rip_lit1_sum", rs, 4'b0001);
        check("rip_lit1_c",   rc[4], 1);
        ripple(4'b1111, 4'b0001);
        check("rip_lit2_sum", rs, 4'b0000);
        check("rip_lit2_c",   rc[4], 1);
        for (int i = 0; i < 50; i++) begin
            ripple(4'($urandom), 4'($urandom));
        end

        // Corrupt the core on one accepted edge
        chk_en = 1'b0;
        step();
        a = 1'b1; b = 1'b0; cin = 1'b0; in_valid = 1'b1;
        force dut.fa_sum = 1'b0;
        step();
        release dut.fa_sum;
        in_valid = 1'b0;
        #1;
        check("err_set", err, 1);
        for (int i = 0; i < 3; i++) begin
            a = 1'($urandom);
            in_valid = 1'b1;
            step();
            check("err_sticky", err, 1);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("err_cleared", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/one_bit_full_adder.md
ONE_BIT_FULL_ADDER -- requirements
Module: one_bit_full_adder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the carry-event counter.
REQ-002 SHALL have port clk, input, 1: single clock; all sequential logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port a, input, 1: addend bit.
REQ-005 SHALL have port b, input, 1: addend bit.
REQ-006 SHALL have port cin, input, 1: carry in.
REQ-007 SHALL have port sum, output, 1: combinational sum bit.
REQ-008 SHALL have port cout, output, 1: combinational carry out.
REQ-009 SHALL have port in_valid, input, 1: qualifies a/b/cin for the registered path.
REQ-010 SHALL have port sum_q, output, 1: registered sum.
REQ-011 SHALL have port cout_q, output, 1: registered carry out.
REQ-012 SHALL have port out_valid, output, 1: sum_q/cout_q hold a fresh result.
REQ-013 SHALL have port carry_cnt, output, CNT_W: count of accepted operations with cout=1.
REQ-014 SHALL have port err, output, 1: sticky self-check mismatch flag.

Function
REQ-015 SHALL drive sum = a XOR b XOR cin, combinationally, zero cycles latency, independent of clk, rst_n and in_valid.
REQ-016 SHALL drive cout = (a AND b) OR (cin AND (a XOR b)), combinationally.
REQ-017 SHALL, at each rising clk edge with in_valid=1, load sum_q/cout_q with the current sum/cout and set out_valid=1: one-cycle latency.
REQ-018 SHALL, on an edge with in_valid=0, hold sum_q/cout_q and clear out_valid to 0.
REQ-019 SHALL increment carry_cnt by 1 on each edge with in_valid=1 and cout=1; saturate at all-ones (no wrap).
REQ-020 SHALL compute a second, independent reference result as the 2-bit value a+b+cin, and set err=1 on any in_valid edge where {cout,sum} differs from it.
REQ-021 SHALL keep err at 1 until reset; err never clears otherwise.
REQ-022 SHALL treat the combinational path as the primary function; it must be usable with clk idle and rst_n in any state.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force sum_q=0, cout_q=0, out_valid=0, carry_cnt=0, err=0.
REQ-024 SHALL, when reset is asserted mid-operation, discard the pending registered result; first valid result after release appears one edge after the first in_valid=1 edge.
REQ-025 SHALL NOT let reset affect sum or cout.

Structure
REQ-026 SHALL place CNT_W default and any shared bit-width constants in the shared adder package; no typedefs required.
REQ-027 SHALL implement the combinational adder as one sub-module, fa_core (a, b, cin -> sum, cout), instantiated once; registered path, counter and checker stay in the top.
REQ-028 SHALL be chainable: four instances with cout feeding the next cin form a 4-bit ripple adder with first cin tied to 0.

Verification
REQ-029 SHALL cover all 8 (a,b,cin) combinations combinationally: e.g. 1,1,1 -> sum=1, cout=1; 1,0,0 -> sum=1, cout=0; 0,0,0 -> 0,0.
REQ-030 SHALL cover registered path: in_valid=1 with a=1,b=1,cin=0 on edge N -> sum_q=0, cout_q=1, out_valid=1 after edge N; in_valid=0 at edge N+1 -> out_valid=0, sum_q/cout_q held.
REQ-031 SHALL cover 4-bit ripple chain: A=4'b1011, B=4'b0110 -> Sum=4'b0001, final carry=1; A=4'b1111, B=4'b0001 -> Sum=4'b0000, carry=1; 50 random pairs checked against A+B.
REQ-032 SHALL cover counter saturation with CNT_W=2: 5 accepted operations with cout=1 -> carry_cnt=3.
REQ-033 SHALL cover async reset mid-stream: rst_n low between edges -> sum_q, cout_q, out_valid, carry_cnt, err all 0 immediately; sum/cout keep tracking inputs.
REQ-034 SHALL cover checker: err stays 0 over all 8 combinations; with fa_core output forced wrong on one accepted edge, err=1 and remains 1 until rst_n=0.
